pipeline_stall_ctrl: RTL and testbench

- Responder to the ID-stage load-use hazard detector and to the split I/D memory handshakes.
- Converts the bubble request, memory wait states and EX-stage branch redirects into per-stage load enables, NOP-injection selects and the PC redirect source for the 5-stage rv32i pipeline.
- Owns the only pipeline-control state: the outstanding-fetch discard tracker and the latched redirect target.

---
 rtl/pipeline_stall_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall, flush and PC-redirect control for a 5-stage rv32i pipeline. It tracks fetches
// that belong to a squashed path. Define STALL_PERF_EN to add saturating stall counters.
module pipeline_stall_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned PERF_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_use_req,
  input  logic            imem_read,
  input  logic            imem_resp,
  input  logic            dmem_read,
  input  logic            dmem_write,
  input  logic            dmem_resp,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            pc_load,
  output logic            pc_redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            if_id_load,
  output logic            id_ex_load,
  output logic            ex_mem_load,
  output logic            mem_wb_load,
  output logic            if_id_flush,
  output logic            id_ex_bubble
`ifdef STALL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_dmem,
  output logic [PERF_W-1:0] perf_imem,
  output logic [PERF_W-1:0] perf_lu,
  output logic [PERF_W-1:0] perf_flush
`endif
);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_DISCARD = 1'b1;

  // The single action chosen this cycle, in strict priority order.
  localparam logic [2:0] ACT_IDLE       = 3'd0;
  localparam logic [2:0] ACT_FREEZE     = 3'd1;
  localparam logic [2:0] ACT_DISC_WAIT  = 3'd2;
  localparam logic [2:0] ACT_DISC_DONE  = 3'd3;
  localparam logic [2:0] ACT_BRANCH     = 3'd4;
  localparam logic [2:0] ACT_BR_DEFER   = 3'd5;
  localparam logic [2:0] ACT_LOAD_USE   = 3'd6;
  localparam logic [2:0] ACT_FETCH_WAIT = 3'd7;

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic [2:0]      act;
  logic            dmem_busy;
  logic            imem_busy;

  assign dmem_busy = (dmem_read | dmem_write) & ~dmem_resp;
  assign imem_busy = imem_read & ~imem_resp;

  // While rst is high the outputs show the idle RUN values regardless of inputs.
  always_comb begin
    if (rst)                        act = ACT_IDLE;
    else if (dmem_busy)             act = ACT_FREEZE;
    else if (state_q == ST_DISCARD) act = imem_resp ? ACT_DISC_DONE : ACT_DISC_WAIT;
    else if (br_taken && !imem_busy) act = ACT_BRANCH;
    else if (br_taken)              act = ACT_BR_DEFER;
    else if (load_use_req)          act = ACT_LOAD_USE;
    else if (imem_busy)             act = ACT_FETCH_WAIT;
    else                            act = ACT_IDLE;
  end

  always_comb begin
    // NOTE: every output and next-state value gets a default here so that no
    // path through the case leaves a signal unassigned and infers a latch.
    pc_load      = 1'b1;
    pc_redirect  = 1'b0;
    redirect_pc  = br_target;
    if_id_load   = 1'b1;
    id_ex_load   = 1'b1;
    ex_mem_load  = 1'b1;
    mem_wb_load  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    state_d      = state_q;
    tgt_d        = tgt_q;

    case (act)
      ACT_FREEZE: begin
        pc_load     = 1'b0;
        if_id_load  = 1'b0;
        id_ex_load  = 1'b0;
        ex_mem_load = 1'b0;
        mem_wb_load = 1'b0;
      end
      ACT_DISC_WAIT: begin
        pc_load      = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      ACT_DISC_DONE: begin
        pc_redirect  = 1'b1;
        redirect_pc  = tgt_q;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        state_d      = ST_RUN;
      end
      ACT_BRANCH: begin
        pc_redirect  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end
      ACT_BR_DEFER: begin
        // The PC must not move while a fetch is outstanding; remember the target.
        pc_load      = 1'b0;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        tgt_d        = br_target;
        state_d      = ST_DISCARD;
      end
      ACT_LOAD_USE: begin
        pc_load      = 1'b0;
        if_id_load   = 1'b0;
        id_ex_bubble = 1'b1;
      end
      ACT_FETCH_WAIT: begin
        pc_load     = 1'b0;
        if_id_flush = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [PERF_W-1:0] perf_dmem_q, perf_dmem_d;
  logic [PERF_W-1:0] perf_imem_q, perf_imem_d;
  logic [PERF_W-1:0] perf_lu_q,   perf_lu_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v, input logic en);
    return (en && !(&v)) ? v + 1'b1 : v;
  endfunction

  always_comb begin
    perf_dmem_d  = sat_inc(perf_dmem_q, act == ACT_FREEZE);
    perf_imem_d  = sat_inc(perf_imem_q, (act == ACT_DISC_WAIT) || (act == ACT_DISC_DONE) ||
                                        (act == ACT_FETCH_WAIT));
    perf_lu_d    = sat_inc(perf_lu_q, act == ACT_LOAD_USE);
    perf_flush_d = sat_inc(perf_flush_q, (act == ACT_BRANCH) || (act == ACT_BR_DEFER));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_dmem_q  <= '0;
      perf_imem_q  <= '0;
      perf_lu_q    <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_dmem_q  <= perf_dmem_d;
      perf_imem_q  <= perf_imem_d;
      perf_lu_q    <= perf_lu_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_dmem  = perf_dmem_q;
  assign perf_imem  = perf_imem_q;
  assign perf_lu    = perf_lu_q;
  assign perf_flush = perf_flush_q;
`else
  if (PERF_W == 0) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: each stimulus cycle queues its expected
// control word and an independent negedge monitor compares the DUT outputs against it.
module tb_pipeline_stall_ctrl;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned PERF_W = 4;

  // Flag byte order: {pc_load, pc_redirect, if_id_load, id_ex_load,
  //                   ex_mem_load, mem_wb_load, if_id_flush, id_ex_bubble}
  localparam logic [7:0] F_RUN    = 8'hBC;
  localparam logic [7:0] F_FREEZE = 8'h00;
  localparam logic [7:0] F_BRANCH = 8'hFF;
  localparam logic [7:0] F_DISC   = 8'h3F;
  localparam logic [7:0] F_LU     = 8'h1D;
  localparam logic [7:0] F_FETCH  = 8'h3E;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            load_use_req = 1'b0;
  logic            imem_read = 1'b0;
  logic            imem_resp = 1'b0;
  logic            dmem_read = 1'b0;
  logic            dmem_write = 1'b0;
  logic            dmem_resp = 1'b0;
  logic            br_taken = 1'b0;
  logic [XLEN-1:0] br_target = '0;
  logic            pc_load, pc_redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
  logic            if_id_flush, id_ex_bubble;
`ifdef STALL_PERF_EN
  logic [PERF_W-1:0] perf_dmem, perf_imem, perf_lu, perf_flush;
`endif

  pipeline_stall_ctrl #(.XLEN(XLEN), .PERF_W(PERF_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_use_req (load_use_req),
    .imem_read    (imem_read),
    .imem_resp    (imem_resp),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_resp    (dmem_resp),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .pc_load      (pc_load),
    .pc_redirect  (pc_redirect),
    .redirect_pc  (redirect_pc),
    .if_id_load   (if_id_load),
    .id_ex_load   (id_ex_load),
    .ex_mem_load  (ex_mem_load),
    .mem_wb_load  (mem_wb_load),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble)
`ifdef STALL_PERF_EN
    ,
    .perf_dmem    (perf_dmem),
    .perf_imem    (perf_imem),
    .perf_lu      (perf_lu),
    .perf_flush   (perf_flush)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [39:0] exp_q[$];
  string       name_q[$];

  task automatic check(input string name, input logic [39:0] actual, input logic [39:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // One stimulus cycle: drive inputs just after the edge and queue the expectation.
  task automatic step(input logic r, input logic lu, input logic ir, input logic irsp,
                      input logic dr, input logic dw, input logic drsp, input logic bt,
                      input logic [XLEN-1:0] tgt, input logic [7:0] f,
                      input logic [XLEN-1:0] rpc, input string name);
    @(posedge clk);
    #1;
    rst          = r;
    load_use_req = lu;
    imem_read    = ir;
    imem_resp    = irsp;
    dmem_read    = dr;
    dmem_write   = dw;
    dmem_resp    = drsp;
    br_taken     = bt;
    br_target    = tgt;
    exp_q.push_back({f, rpc});
    name_q.push_back(name);
  endtask

  initial begin : monitor
    logic [39:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, {pc_load, pc_redirect, if_id_load, id_ex_load, ex_mem_load,
                  mem_wb_load, if_id_flush, id_ex_bubble, redirect_pc}, e);
      end
    end
  end

  initial begin : stimulus
    int budget;
    //    rst  lu   ir   irsp dr   dw   drsp bt   tgt       flags     rpc
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h44, F_RUN, 32'h44, "reset_outputs");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_RUN, 32'h0, "idle");

    // Single load-use bubble, then normal flow.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_LU, 32'h0, "load_use");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_RUN, 32'h0, "after_load_use");

    // Data stall dominates branch and load-use, then branch wins on dmem_resp.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, F_FREEZE, 32'h80, "dmem_freeze");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h80, F_BRANCH, 32'h80, "dmem_done_branch");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, F_FREEZE, 32'h0, "store_freeze");

    // Immediate redirect with idle memories, also over a load-use request.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h60, F_BRANCH, 32'h60, "branch_idle");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h74, F_BRANCH, 32'h74, "branch_over_lu");

    // Load-use outranks an outstanding fetch.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_LU, 32'h0, "lu_over_fetch");

    // Fetch wait states: front end flushes, back end advances.
    for (int i = 0; i < 2; i++)
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_FETCH, 32'h0, "fetch_wait");

    // Branch during outstanding fetch: deferred redirect at imem_resp.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100, F_DISC, 32'h100, "defer_branch");
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, F_DISC, 32'h100, "discard_wait");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_BRANCH, 32'h100, "discard_redirect");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_RUN, 32'h0, "back_to_run");

    // A data stall inside DISCARD freezes and keeps the latched target.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2A0, F_DISC, 32'h2A0, "defer_branch2");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, F_FREEZE, 32'h0, "discard_freeze");
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h4, F_BRANCH, 32'h2A0, "discard_redirect2");

    // Reset mid-DISCARD returns to RUN.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h300, F_DISC, 32'h300, "defer_branch3");
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h300, F_RUN, 32'h300, "reset_in_discard");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_RUN, 32'h0, "run_after_reset");

`ifdef STALL_PERF_EN
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_RUN, 32'h0, "perf_reset");
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, F_FREEZE, 32'h0, "perf_dmem_stall");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_LU, 32'h0, "perf_lu_cycle");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_RUN, 32'h0, "perf_idle");
    check("perf_dmem_3", {36'd0, perf_dmem}, 40'd3);
    check("perf_lu_1", {36'd0, perf_lu}, 40'd1);
    check("perf_imem_0", {36'd0, perf_imem}, 40'd0);
    check("perf_flush_0", {36'd0, perf_flush}, 40'd0);
    for (int i = 0; i < 14; i++)
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, F_FREEZE, 32'h0, "perf_sat_stall");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, F_RUN, 32'h0, "perf_idle2");
    check("perf_dmem_saturated", {36'd0, perf_dmem}, 40'd15);
`endif

    budget = 0;
    while (exp_q.size() != 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
